// File: rtl/gcd_stream_pkg.sv
// Shared constants and state encoding for the GCD result stream stage.
package gcd_stream_pkg;

  localparam int RES_W        = 1284;
  localparam int BEAT_W       = 64;
  localparam int BEATS_PER_OP = 21;
  localparam int PAD_W        = BEATS_PER_OP * BEAT_W - RES_W;
  localparam int PKT_BEATS    = 2 * BEATS_PER_OP;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } state_e;

endpackage

// File: rtl/gcd_result_streamer.sv
// Snapshots both Bezout coefficients on each GCD done pulse and streams them
// as one AXI4-Stream packet: 21 beats of A followed by 21 beats of B.
module gcd_result_streamer #(
  parameter int RES_W        = 1284,
  parameter int BEAT_W       = 64,
  parameter int BEATS_PER_OP = 21
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              CLKEN,
  input  logic              ENABLE,
  input  logic              DONE_PULSE,
  input  logic [RES_W-1:0]  BEZOUT_A,
  input  logic [RES_W-1:0]  BEZOUT_B,
  input  logic              OVF_CLR,
  output logic [BEAT_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST,
  output logic              M_AXIS_TUSER,
  output logic              BUSY,
  output logic              OVERFLOW
);
  import gcd_stream_pkg::*;

  localparam int SR_W     = 2 * BEATS_PER_OP * BEAT_W;
  localparam int PAD_BITS = BEATS_PER_OP * BEAT_W - RES_W;
  localparam logic [4:0] CNT_LAST = 5'(BEATS_PER_OP - 1);

  logic [SR_W-1:0] sr_q, sr_d;
  logic [4:0]      cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic            ovf_q, ovf_d;

  logic busy;
  logic accept;
  logic last_beat;
  logic final_accept;
  logic done_req;
  logic capture;
  logic ovf_set;

  // Handshake and event decode; CLKEN gates every state-changing event
  assign busy         = (state_q != IDLE);
  assign accept       = busy & M_AXIS_TREADY & CLKEN;
  assign last_beat    = (cnt_q == CNT_LAST);
  assign final_accept = accept & (state_q == SEND_B) & last_beat;
  assign done_req     = CLKEN & ENABLE & DONE_PULSE;
  // The final-beat cycle frees the register, so a result arriving then
  // starts the next packet instead of being dropped
  assign capture      = done_req & (~busy | final_accept);
  assign ovf_set      = done_req & busy & ~final_accept;

  // Next-state for shift register, beat counter, FSM and sticky overflow
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    ovf_d   = ovf_q;

    if (accept) begin
      sr_d  = sr_q >> BEAT_W;
      cnt_d = last_beat ? 5'd0 : cnt_q + 5'd1;
      case (state_q)
        SEND_A:  if (last_beat) state_d = SEND_B;
        SEND_B:  if (last_beat) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end

    if (capture) begin
      sr_d    = {{PAD_BITS{1'b0}}, BEZOUT_B, {PAD_BITS{1'b0}}, BEZOUT_A};
      cnt_d   = 5'd0;
      state_d = SEND_A;
    end

    // Set after clear so a simultaneous new overflow is never lost
    if (CLKEN & OVF_CLR) ovf_d = 1'b0;
    if (ovf_set)         ovf_d = 1'b1;
  end

  // State registers; reset aborts any packet in flight
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sr_q    <= '0;
      cnt_q   <= 5'd0;
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Stream outputs come straight from registered state; TVALID is masked
  // by CLKEN so no handshake can complete while the clock is disabled
  assign M_AXIS_TDATA  = sr_q[BEAT_W-1:0];
  assign M_AXIS_TVALID = busy & CLKEN;
  assign M_AXIS_TUSER  = (state_q == SEND_B);
  assign M_AXIS_TLAST  = (state_q == SEND_B) & last_beat;
  assign BUSY          = busy;
  assign OVERFLOW      = ovf_q;

endmodule

// File: tb/tb_gcd_result_streamer.sv
// Directed bench for gcd_result_streamer: single packet, backpressure,
// overflow, back-to-back, clock-enable/enable gating and mid-packet reset.
module tb_gcd_result_streamer;
  import gcd_stream_pkg::*;

  logic              CLK;
  logic              RESETn;
  logic              CLKEN;
  logic              ENABLE;
  logic              DONE_PULSE;
  logic [RES_W-1:0]  BEZOUT_A;
  logic [RES_W-1:0]  BEZOUT_B;
  logic              OVF_CLR;
  logic [BEAT_W-1:0] M_AXIS_TDATA;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TREADY;
  logic              M_AXIS_TLAST;
  logic              M_AXIS_TUSER;
  logic              BUSY;
  logic              OVERFLOW;

  gcd_result_streamer #(
    .RES_W(RES_W), .BEAT_W(BEAT_W), .BEATS_PER_OP(BEATS_PER_OP)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .CLKEN(CLKEN), .ENABLE(ENABLE),
    .DONE_PULSE(DONE_PULSE), .BEZOUT_A(BEZOUT_A), .BEZOUT_B(BEZOUT_B),
    .OVF_CLR(OVF_CLR), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TUSER(M_AXIS_TUSER), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RES_W-1:0] ea, eb, pa, pb;
  logic [63:0]      bd [PKT_BEATS];
  logic             bu [PKT_BEATS];
  logic             bl [PKT_BEATS];
  int               nb, stall_err, gap_err, clk_err, user_err, last_err;
  logic [BEATS_PER_OP*BEAT_W-1:0] rpa, rpb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] rnd_res();
    logic [RES_W-1:0] v;
    v = '0;
    for (int k = 0; k < 41; k++) v = (v << 32) | RES_W'($urandom);
    return v;
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 of the first beat cycle
  task automatic start(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b);
    ea = a; eb = b;
    BEZOUT_A = a; BEZOUT_B = b;
    DONE_PULSE = 1'b1;
    @(posedge CLK); #1;
    DONE_PULSE = 1'b0;
  endtask

  // Drains one packet. rnd: random TREADY. pulse_at: beat index whose
  // handshake cycle also carries DONE_PULSE with pa/pb. off_at: beat index
  // before which CLKEN drops for 5 cycles. abort_at: beat index at which
  // RESETn is asserted and the task returns.
  task automatic recv(input bit rnd, input int pulse_at, input int off_at, input int abort_at);
    int cyc, off_left;
    bit have_prev, off_done;
    logic [63:0] pd;
    logic pu, pl;
    nb = 0; stall_err = 0; gap_err = 0; clk_err = 0; user_err = 0; last_err = 0;
    cyc = 0; off_left = 0; have_prev = 0; off_done = 0;
    pd = '0; pu = 1'b0; pl = 1'b0;
    while (nb < PKT_BEATS && cyc < 2000) begin
      cyc++;
      if (off_at == nb && !off_done) begin off_left = 5; off_done = 1; end
      if (off_left > 0) begin CLKEN = 1'b0; off_left--; end
      else CLKEN = 1'b1;
      M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (abort_at == nb) begin
        chk("rst_ovf_pre", OVERFLOW, 1);
        RESETn = 1'b0;
        #1;
        chk("rst_tvalid", M_AXIS_TVALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ovf", OVERFLOW, 0);
        return;
      end
      if (have_prev && (M_AXIS_TDATA !== pd || M_AXIS_TUSER !== pu || M_AXIS_TLAST !== pl))
        stall_err++;
      if (CLKEN && !M_AXIS_TVALID) gap_err++;
      if (!CLKEN && M_AXIS_TVALID) clk_err++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        bd[nb] = M_AXIS_TDATA;
        bu[nb] = M_AXIS_TUSER;
        bl[nb] = M_AXIS_TLAST;
        if (M_AXIS_TUSER !== (nb >= BEATS_PER_OP)) user_err++;
        if (M_AXIS_TLAST !== (nb == PKT_BEATS - 1)) last_err++;
        if (pulse_at == nb) begin
          BEZOUT_A = pa; BEZOUT_B = pb; DONE_PULSE = 1'b1;
        end
        have_prev = 0;
        nb++;
      end else begin
        have_prev = 1;
        pd = M_AXIS_TDATA; pu = M_AXIS_TUSER; pl = M_AXIS_TLAST;
      end
      @(posedge CLK); #1;
      DONE_PULSE = 1'b0;
    end
    CLKEN = 1'b1;
    for (int k = 0; k < BEATS_PER_OP; k++) begin
      rpa[64*k +: 64] = (k < nb) ? bd[k] : 64'hX;
      rpb[64*k +: 64] = (k + BEATS_PER_OP < nb) ? bd[k + BEATS_PER_OP] : 64'hX;
    end
  endtask

  // Common whole-packet checks
  task automatic chk_pkt(input string tag);
    chk({tag, "_beats"}, 64'(nb), 64'(PKT_BEATS));
    chk({tag, "_a"}, 64'(rpa === {{PAD_W{1'b0}}, ea}), 1);
    chk({tag, "_b"}, 64'(rpb === {{PAD_W{1'b0}}, eb}), 1);
    chk({tag, "_user"}, 64'(user_err), 0);
    chk({tag, "_last"}, 64'(last_err), 0);
    chk({tag, "_stall"}, 64'(stall_err), 0);
  endtask

  initial begin
    RESETn = 1'b0; CLKEN = 1'b1; ENABLE = 1'b1; DONE_PULSE = 1'b0;
    BEZOUT_A = '0; BEZOUT_B = '0; OVF_CLR = 1'b0; M_AXIS_TREADY = 1'b0;
    pa = '0; pb = '0; ea = '0; eb = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_tvalid", M_AXIS_TVALID, 0);
    chk("reset_tdata", M_AXIS_TDATA, 0);
    chk("reset_tlast", M_AXIS_TLAST, 0);
    chk("reset_tuser", M_AXIS_TUSER, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_ovf", OVERFLOW, 0);
    RESETn = 1'b1;
    @(posedge CLK); #1;

    // Single result with A = 1, B = all ones
    start(RES_W'(1), '1);
    chk("single_latency_tvalid", M_AXIS_TVALID, 1);
    chk("single_latency_tdata", M_AXIS_TDATA, 64'h1);
    recv(0, -1, -1, -1);
    chk_pkt("single");
    chk("single_gap", 64'(gap_err), 0);
    chk("single_beat0", bd[0], 64'h1);
    chk("single_beat1", bd[1], 64'h0);
    chk("single_beat20", bd[20], 64'h0);
    chk("single_beat20_user", bu[20], 0);
    chk("single_beat21", bd[21], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("single_beat41", bd[41], 64'h0000_0000_0000_000F);
    chk("single_beat41_user", bu[41], 1);
    chk("single_beat41_last", bl[41], 1);
    chk("single_busy_after", BUSY, 0);
    chk("single_tvalid_after", M_AXIS_TVALID, 0);

    // Random backpressure
    start(rnd_res(), rnd_res());
    recv(1, -1, -1, -1);
    chk_pkt("bp");

    // Overflow at beat 10, then clear-versus-set, then clear alone
    pa = rnd_res(); pb = rnd_res();
    start(rnd_res(), rnd_res());
    recv(0, 10, -1, -1);
    chk_pkt("ovf");
    chk("ovf_set", OVERFLOW, 1);
    start(rnd_res(), rnd_res());
    M_AXIS_TREADY = 1'b0;
    BEZOUT_A = pa; BEZOUT_B = pb;
    OVF_CLR = 1'b1; DONE_PULSE = 1'b1;
    @(posedge CLK); #1;
    OVF_CLR = 1'b0; DONE_PULSE = 1'b0;
    chk("ovf_clr_vs_set", OVERFLOW, 1);
    OVF_CLR = 1'b1;
    @(posedge CLK); #1;
    OVF_CLR = 1'b0;
    chk("ovf_clr_alone", OVERFLOW, 0);
    recv(0, -1, -1, -1);
    chk_pkt("ovf_clr_pkt");

    // Back-to-back: new result on the final-beat handshake
    pa = rnd_res(); pb = rnd_res();
    start(rnd_res(), rnd_res());
    recv(0, PKT_BEATS - 1, -1, -1);
    chk_pkt("b2b_first");
    chk("b2b_tvalid", M_AXIS_TVALID, 1);
    chk("b2b_beat0", M_AXIS_TDATA, pa[63:0]);
    chk("b2b_tuser", M_AXIS_TUSER, 0);
    chk("b2b_ovf", OVERFLOW, 0);
    ea = pa; eb = pb;
    recv(0, -1, -1, -1);
    chk_pkt("b2b_second");
    chk("b2b_second_gap", 64'(gap_err), 0);

    // CLKEN low for 5 cycles mid-packet
    start(rnd_res(), rnd_res());
    recv(0, -1, 7, -1);
    chk_pkt("clken");
    chk("clken_tvalid_low", 64'(clk_err), 0);
    chk("clken_gap", 64'(gap_err), 0);

    // ENABLE low: ignored while busy, packet continues, ignored in idle
    start(rnd_res(), rnd_res());
    ENABLE = 1'b0;
    M_AXIS_TREADY = 1'b0;
    BEZOUT_A = '1; BEZOUT_B = '1; DONE_PULSE = 1'b1;
    @(posedge CLK); #1;
    DONE_PULSE = 1'b0;
    chk("en_busy_ovf", OVERFLOW, 0);
    recv(0, -1, -1, -1);
    chk_pkt("en_low_pkt");
    DONE_PULSE = 1'b1;
    @(posedge CLK); #1;
    DONE_PULSE = 1'b0;
    chk("en_idle_busy", BUSY, 0);
    chk("en_idle_tvalid", M_AXIS_TVALID, 0);
    chk("en_idle_ovf", OVERFLOW, 0);
    ENABLE = 1'b1;

    // Reset at beat 15 with OVERFLOW set, then a clean packet
    pa = rnd_res(); pb = rnd_res();
    start(rnd_res(), rnd_res());
    recv(0, 10, -1, 15);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_tvalid", M_AXIS_TVALID, 0);
    chk("post_rst_tdata", M_AXIS_TDATA, 0);
    start(rnd_res(), rnd_res());
    chk("post_rst_latency", M_AXIS_TVALID, 1);
    recv(0, -1, -1, -1);
    chk_pkt("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
